// File: rtl/pd_pkg.sv
// Shared definitions for the multi-channel 110110 pattern detector:
// FSM encoding, default pattern constants and the channel-index width helper.
package pd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int              PD_PLEN    = 6;
    localparam logic [PD_PLEN-1:0] PD_PATTERN = 6'b110110;

    // Width of an index into n channels; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pd_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above i_ptr, wrapping,
// and reports the winner both one-hot and encoded. No grant while i_en is low.
module pd_rr_arb
    import pd_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = ch_w(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [IW-1:0]  i_ptr,
    input  logic           i_en,
    output logic [NCH-1:0] o_gnt,
    output logic [IW-1:0]  o_idx
);

    localparam int SW = IW + 1;

    logic [SW-1:0] w_sum;

    // Scan offsets from the far end down so the nearest requester is written last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_sum = '0;
        if (i_en) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                w_sum = {1'b0, i_ptr} + SW'(i);
                if (w_sum >= SW'(NCH)) begin
                    w_sum = w_sum - SW'(NCH);
                end
                if (i_req[w_sum[IW-1:0]]) begin
                    o_gnt                 = '0;
                    o_gnt[w_sum[IW-1:0]]  = 1'b1;
                    o_idx                 = w_sum[IW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/pd_sched.sv
// One shared 110110 serial detector time-multiplexed over NCH bit streams,
// with per-channel history, a saturating match counter and a stop threshold.
module pd_sched
    import pd_pkg::*;
#(
    parameter int              NCH     = 4,
    parameter int              PLEN    = PD_PLEN,
    parameter logic [PLEN-1:0] PATTERN = PD_PATTERN,
    parameter int              CW      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic                    overlap_i,
    input  logic [CW-1:0]           thr_i,
    input  logic [NCH-1:0]          valid_i,
    input  logic [NCH-1:0]          data_i,
    output logic [NCH-1:0]          ready_o,
    output logic                    pd_o,
    output logic [$clog2(NCH)-1:0]  pd_ch_o,
    output logic [CW-1:0]           cnt_o,
    output logic                    done_o,
    output logic                    busy_o
);

    localparam int IW = $clog2(NCH);
    localparam int FW = $clog2(PLEN);

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ptr;
    logic [PLEN-2:0] r_hist [NCH];
    logic [FW-1:0]   r_fill [NCH];
    logic [CW-1:0]   r_cnt;
    logic            r_pd;
    logic [IW-1:0]   r_pd_ch;

    logic            w_arb_en;
    logic [NCH-1:0]  w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_xfer;
    logic [PLEN-1:0] w_cand;
    logic            w_full;
    logic            w_match;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_hit_thr;
    logic [IW-1:0]   w_ptr_next;

    // Handshake: a bit moves on channel k when valid_i[k] & ready_o[k] at a rising edge;
    // ready_o is one-hot, only in RUN with en_i=1 and clr_i=0, and never depends on data_i.
    assign w_arb_en = (r_state == S_RUN) && en_i && !clr_i;

    pd_rr_arb #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arb (
        .i_req (valid_i),
        .i_ptr (r_ptr),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign ready_o    = w_gnt;
    assign w_xfer     = |(w_gnt & valid_i);
    assign w_cand     = {r_hist[w_idx], data_i[w_idx]};
    assign w_full     = (r_fill[w_idx] == FW'(PLEN - 1));
    assign w_match    = w_xfer && w_full && (w_cand == PATTERN);
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
    assign w_hit_thr  = (thr_i != '0) && (w_cnt_inc >= thr_i);
    assign w_ptr_next = (w_idx == IW'(NCH - 1)) ? '0 : w_idx + IW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!clr_i && en_i) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (clr_i || !en_i) begin
                    w_next = S_IDLE;
                end else if (w_match && w_hit_thr) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (clr_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The pointer survives clr_i so fairness is not reset by a soft clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            for (int k = 0; k < NCH; k++) begin
                r_hist[k] <= '0;
                r_fill[k] <= '0;
            end
        end else if (w_xfer) begin
            if (w_match && !overlap_i) begin
                r_hist[w_idx] <= '0;
                r_fill[w_idx] <= '0;
            end else begin
                r_hist[w_idx] <= w_cand[PLEN-2:0];
                if (!w_full) begin
                    r_fill[w_idx] <= r_fill[w_idx] + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_pd    <= 1'b0;
            r_pd_ch <= '0;
            r_cnt   <= '0;
        end else begin
            r_pd <= w_match;
            if (w_match) begin
                r_pd_ch <= w_idx;
                r_cnt   <= w_cnt_inc;
            end
        end
    end

    assign pd_o    = r_pd;
    assign pd_ch_o = r_pd_ch;
    assign cnt_o   = r_cnt;
    assign done_o  = (r_state == S_DONE);
    assign busy_o  = (r_state == S_RUN);

endmodule

// File: tb/tb_pd_sched.sv
// Bench for pd_sched: directed scenarios plus random streams, checked against
// a bit-queue reference model with an expected-pulse scoreboard.
module tb_pd_sched;

    localparam int              NCH  = 4;
    localparam int              CW   = 8;
    localparam int              PLEN = 6;
    localparam logic [PLEN-1:0] PAT  = 6'b110110;
    localparam int              EW   = 40;

    logic           clk = 1'b0;
    logic           rst_i, en_i, clr_i, overlap_i;
    logic [CW-1:0]  thr_i;
    logic [NCH-1:0] valid_i, data_i, ready_o;
    logic           pd_o;
    logic [1:0]     pd_ch_o;
    logic [CW-1:0]  cnt_o;
    logic           done_o, busy_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state: 0 idle, 1 run, 2 done
    int m_state = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit chq [NCH][$];

    logic [EW-1:0] exp_q [$];

    bit             tx_q [NCH][$];
    logic [NCH-1:0] gnt_seen;
    int             grant_log [$];
    bit             force_all = 1'b0;

    pd_sched #(
        .NCH (NCH),
        .CW  (CW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .clr_i     (clr_i),
        .overlap_i (overlap_i),
        .thr_i     (thr_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .pd_o      (pd_o),
        .pd_ch_o   (pd_ch_o),
        .cnt_o     (cnt_o),
        .done_o    (done_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: checks the current cycle's outputs, then advances one edge.
    always @(negedge clk) begin
        logic [NCH-1:0] e_ready;
        int g;
        int v;
        bit hit;
        e_ready = '0;
        g       = -1;
        hit     = 1'b0;
        if (m_state == 1 && en_i === 1'b1 && clr_i === 1'b0) begin
            for (int i = 0; i < NCH; i++) begin
                int k;
                k = (m_ptr + i) % NCH;
                if (g < 0 && valid_i[k] === 1'b1) begin
                    g          = k;
                    e_ready[k] = 1'b1;
                end
            end
        end
        chk("ready", 32'(ready_o), 32'(e_ready));
        chk("busy", 32'(busy_o), 32'(m_state == 1));
        chk("done", 32'(done_o), 32'(m_state == 2));
        chk("cnt", 32'(cnt_o), 32'(m_cnt));

        if (rst_i) begin
            m_state = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            for (int k = 0; k < NCH; k++) chq[k].delete();
        end else if (clr_i) begin
            m_state = 0;
            m_cnt   = 0;
            for (int k = 0; k < NCH; k++) chq[k].delete();
        end else begin
            if (g >= 0) begin
                chq[g].push_back(data_i[g]);
                if (chq[g].size() > PLEN) void'(chq[g].pop_front());
                if (chq[g].size() == PLEN) begin
                    v = 0;
                    for (int i = 0; i < PLEN; i++) v = v * 2 + int'(chq[g][i]);
                    hit = (v == int'(PAT));
                end
                if (hit) begin
                    exp_q.push_back({32'(cyc + 1), 8'(g)});
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                    if (!overlap_i) chq[g].delete();
                end
                m_ptr = (g + 1) % NCH;
            end
            case (m_state)
                0: if (en_i) m_state = 1;
                1: begin
                    if (!en_i) m_state = 0;
                    else if (hit && thr_i != 0 && m_cnt >= int'(thr_i)) m_state = 2;
                end
                default: m_state = 2;
            endcase
        end
    end

    // Monitor: consumes one expected pulse whenever pd_o fires or one falls due.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (pd_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pd_spurious: got pd_o=1 ch=%0d expected no pulse at cycle %0d", pd_ch_o, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pd_cycle", 32'(cyc), e[39:8]);
                chk("pd_ch", 32'(pd_ch_o), 32'(e[7:0]));
            end
        end else if (exp_q.size() > 0 && exp_q[0][39:8] <= 32'(cyc)) begin
            e = exp_q.pop_front();
            chk("pd_pulse", 32'(pd_o), 32'd1);
        end
    end

    function automatic bit all_empty();
        for (int k = 0; k < NCH; k++) if (tx_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < NCH; k++) begin
            if (force_all) begin
                valid_i[k] = 1'b1;
                data_i[k]  = 1'($urandom_range(0, 1));
            end else if (tx_q[k].size() > 0) begin
                valid_i[k] = 1'b1;
                data_i[k]  = tx_q[k][0];
            end else begin
                valid_i[k] = 1'b0;
                data_i[k]  = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        gnt_seen = valid_i & ready_o;
        for (int k = 0; k < NCH; k++) if (gnt_seen[k]) grant_log.push_back(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_seen[k] && tx_q[k].size() > 0) void'(tx_q[k].pop_front());
        end
        drive_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_bits(input int ch, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) tx_q[ch].push_back(v[i]);
        drive_inputs();
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (!all_empty() && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (!all_empty()) begin
            errors++;
            $display("FAIL drain_timeout: got pending bits after %0d cycles expected none", max_cyc);
            for (int k = 0; k < NCH; k++) tx_q[k].delete();
            drive_inputs();
        end
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; overlap_i = 1'b1;
        thr_i = '0; valid_i = '0; data_i = '0;
        idle(3);
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        chk("rst_pd", 32'(pd_o), 32'd0);
        chk("rst_pd_ch", 32'(pd_ch_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        en_i  = 1'b1;
        idle(2);

        // Single channel
        push_bits(0, 32'b110110, 6);
        drain(60);
        idle(3);
        chk("single_cnt", 32'(cnt_o), 32'd1);

        // Interleaved channels, only ch1 matches
        pulse_clr();
        push_bits(1, 32'b110110, 6);
        push_bits(2, 32'b000000, 6);
        drain(60);
        idle(3);
        chk("interleave_cnt", 32'(cnt_o), 32'd1);

        // Overlapping vs non-overlapping
        pulse_clr();
        overlap_i = 1'b1;
        push_bits(0, 32'b110110110, 9);
        drain(60);
        idle(3);
        chk("overlap_cnt", 32'(cnt_o), 32'd2);
        pulse_clr();
        overlap_i = 1'b0;
        push_bits(0, 32'b110110110, 9);
        drain(60);
        idle(3);
        chk("nooverlap_cnt", 32'(cnt_o), 32'd1);
        push_bits(0, 32'b110, 3);
        drain(60);
        idle(3);
        chk("nooverlap_cnt2", 32'(cnt_o), 32'd2);

        // Threshold stop
        pulse_clr();
        overlap_i = 1'b1;
        thr_i     = 8'd2;
        push_bits(3, 32'b110110110, 9);
        drain(60);
        idle(2);
        chk("thr_done", 32'(done_o), 32'd1);
        chk("thr_cnt", 32'(cnt_o), 32'd2);
        force_all = 1'b1;
        drive_inputs();
        idle(6);
        chk("thr_hold_ready", 32'(ready_o), 32'd0);
        force_all = 1'b0;
        drive_inputs();
        pulse_clr();
        thr_i = '0;
        chk("clr_cnt", 32'(cnt_o), 32'd0);
        chk("clr_done", 32'(done_o), 32'd0);
        idle(2);
        chk("clr_busy", 32'(busy_o), 32'd1);

        // Fairness from reset
        en_i = 1'b0;
        idle(2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        grant_log.delete();
        en_i = 1'b1;
        for (int k = 0; k < NCH; k++) push_bits(k, 32'($urandom_range(0, 3)), 2);
        drain(60);
        chk("fair_len", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            chk("fair_order", 32'(grant_log[i]), 32'(i % NCH));
        end

        // Reset mid-stream discards partial history
        pulse_clr();
        push_bits(0, 32'b11011, 5);
        drain(60);
        en_i = 1'b0;
        idle(1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        en_i  = 1'b1;
        push_bits(0, 32'b0, 1);
        drain(60);
        idle(3);
        chk("midrst_nomatch", 32'(cnt_o), 32'd0);
        push_bits(0, 32'b110110, 6);
        drain(60);
        idle(3);
        chk("midrst_match", 32'(cnt_o), 32'd1);

        // Random streams with random enable, overlap and threshold
        for (int r = 0; r < 8; r++) begin
            pulse_clr();
            overlap_i = 1'($urandom_range(0, 1));
            thr_i     = CW'($urandom_range(0, 4));
            for (int k = 0; k < NCH; k++) begin
                for (int c = 0; c < 4; c++) begin
                    case ($urandom_range(0, 3))
                        0: push_bits(k, 32'b110110, 6);
                        1: push_bits(k, 32'b11011, 5);
                        2: push_bits(k, 32'b1, 1);
                        default: push_bits(k, 32'b0, 1);
                    endcase
                end
            end
            for (int i = 0; i < 50; i++) begin
                en_i = ($urandom_range(0, 9) != 0);
                tick();
            end
            en_i = 1'b0;
            for (int k = 0; k < NCH; k++) tx_q[k].delete();
            drive_inputs();
            idle(3);
            en_i = 1'b1;
        end
        thr_i = '0;
        idle(4);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
